// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler
//   Arbitrates refresh, write and read commands towards a downstream DDR
//   command state machine. Owed refreshes win over data commands; writes
//   and reads share the remaining slots round-robin. Each command runs a
//   four-phase handshake (IDLE -> ISSUE -> ACKWAIT -> DONEWAIT) against
//   SM_IDLE, and every wait phase is guarded by a timeout.
//
// Ports
//   CLK, RESET                 clock, synchronous active-low reset
//   WR_REQ, WR_ROW/COL/BA      write request (level) and its address
//   RD_REQ, RD_ROW/COL/BA      read request (level) and its address
//   SM_IDLE                    downstream state machine is idle
//   WR_GNT, RD_GNT             one-cycle grant pulses
//   DONE                       one-cycle completion pulse
//   REF, WRITE, READ           command strobes (one-hot or all low)
//   ROW_OUT, COL_OUT, BA_OUT   address of the current data command
//   PEND_CNT                   number of refreshes owed
//   ERR_TOUT, ERR_OVF          sticky handshake-timeout / refresh-overflow
module ddr_cmd_scheduler #(
  parameter int TREFI    = 6400000,
  parameter int MAX_PEND = 8,
  parameter int TOUT     = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_REQ,
  input  logic [14:0] WR_ROW,
  input  logic [9:0]  WR_COL,
  input  logic [2:0]  WR_BA,
  input  logic        RD_REQ,
  input  logic [14:0] RD_ROW,
  input  logic [9:0]  RD_COL,
  input  logic [2:0]  RD_BA,
  input  logic        SM_IDLE,
  output logic        WR_GNT,
  output logic        RD_GNT,
  output logic        DONE,
  output logic        REF,
  output logic        WRITE,
  output logic        READ,
  output logic [14:0] ROW_OUT,
  output logic [9:0]  COL_OUT,
  output logic [2:0]  BA_OUT,
  output logic [3:0]  PEND_CNT,
  output logic        ERR_TOUT,
  output logic        ERR_OVF
);

  localparam int TMR_W = (TREFI > 1) ? $clog2(TREFI) : 1;
  localparam int TO_W  = (TOUT > 1) ? $clog2(TOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TREFI - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TOUT - 1);
  localparam logic [3:0]       PEND_MAX = 4'(MAX_PEND);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACKWAIT,
    ST_DONEWAIT
  } state_t;

  typedef enum logic [1:0] {
    CMD_REF,
    CMD_WR,
    CMD_RD
  } cmd_t;

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [TO_W-1:0]   tout_q, tout_d;
  logic [3:0]        pend_q, pend_d;
  logic              last_wr_q, last_wr_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              done_q, done_d;
  logic              ref_q, ref_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic [14:0]       row_q, row_d;
  logic [9:0]        col_q, col_d;
  logic [2:0]        ba_q, ba_d;
  logic              err_tout_q, err_tout_d;
  logic              err_ovf_q, err_ovf_d;

  logic              wrap;
  logic              tout_hit;
  logic              ref_done;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tout_d     = tout_q;
    last_wr_d  = last_wr_q;
    wr_gnt_d   = 1'b0;
    rd_gnt_d   = 1'b0;
    done_d     = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    ba_d       = ba_q;
    err_tout_d = err_tout_q;
    err_ovf_d  = err_ovf_q;
    pend_d     = pend_q;
    ref_done   = 1'b0;

    wrap     = (tmr_q == TMR_LAST);
    tmr_d    = wrap ? '0 : tmr_q + 1'b1;
    tout_hit = (tout_q == TO_LAST);

    case (state_q)
      ST_IDLE: begin
        if (SM_IDLE) begin
          if (pend_q != 4'd0) begin
            cmd_d   = CMD_REF;
            state_d = ST_ISSUE;
          end else if (WR_REQ && (!RD_REQ || !last_wr_q)) begin
            // On a tie the requester that was not granted last wins.
            cmd_d     = CMD_WR;
            state_d   = ST_ISSUE;
            wr_gnt_d  = 1'b1;
            last_wr_d = 1'b1;
            row_d     = WR_ROW;
            col_d     = WR_COL;
            ba_d      = WR_BA;
          end else if (RD_REQ) begin
            cmd_d     = CMD_RD;
            state_d   = ST_ISSUE;
            rd_gnt_d  = 1'b1;
            last_wr_d = 1'b0;
            row_d     = RD_ROW;
            col_d     = RD_COL;
            ba_d      = RD_BA;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_ACKWAIT;
        tout_d  = '0;
      end
      ST_ACKWAIT: begin
        if (!SM_IDLE) begin
          state_d = ST_DONEWAIT;
          tout_d  = '0;
        end else if (tout_hit) begin
          state_d    = ST_IDLE;
          err_tout_d = 1'b1;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      ST_DONEWAIT: begin
        if (SM_IDLE) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          ref_done = (cmd_q == CMD_REF);
        end else if (tout_hit) begin
          // A timed-out refresh stays owed and is retried from IDLE.
          state_d    = ST_IDLE;
          err_tout_d = 1'b1;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A wrap and a refresh completion in the same cycle cancel out.
    if (wrap && !ref_done) begin
      if (pend_q == PEND_MAX) begin
        err_ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (ref_done && !wrap) begin
      pend_d = pend_q - 4'd1;
    end

    // Strobes are high exactly while the FSM sits in ACKWAIT.
    ref_d   = (state_d == ST_ACKWAIT) && (cmd_d == CMD_REF);
    write_d = (state_d == ST_ACKWAIT) && (cmd_d == CMD_WR);
    read_d  = (state_d == ST_ACKWAIT) && (cmd_d == CMD_RD);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_REF;
      tmr_q      <= '0;
      tout_q     <= '0;
      pend_q     <= 4'd0;
      last_wr_q  <= 1'b0;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      done_q     <= 1'b0;
      ref_q      <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      ba_q       <= '0;
      err_tout_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tmr_q      <= tmr_d;
      tout_q     <= tout_d;
      pend_q     <= pend_d;
      last_wr_q  <= last_wr_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      done_q     <= done_d;
      ref_q      <= ref_d;
      write_q    <= write_d;
      read_q     <= read_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ba_q       <= ba_d;
      err_tout_q <= err_tout_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  assign WR_GNT   = wr_gnt_q;
  assign RD_GNT   = rd_gnt_q;
  assign DONE     = done_q;
  assign REF      = ref_q;
  assign WRITE    = write_q;
  assign READ     = read_q;
  assign ROW_OUT  = row_q;
  assign COL_OUT  = col_q;
  assign BA_OUT   = ba_q;
  assign PEND_CNT = pend_q;
  assign ERR_TOUT = err_tout_q;
  assign ERR_OVF  = err_ovf_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Bench for ddr_cmd_scheduler: directed scenarios followed by a randomized
// run, all checked every cycle against a transaction-level reference model.
module tb_ddr_cmd_scheduler;

  localparam int TREFI    = 100;
  localparam int MAX_PEND = 8;
  localparam int TOUT     = 10;

  localparam int P_IDLE = 0, P_ISSUE = 1, P_ACK = 2, P_DONE = 3;
  localparam int C_REF = 1, C_WR = 2, C_RD = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WR_REQ, RD_REQ, SM_IDLE;
  logic [14:0] WR_ROW, RD_ROW;
  logic [9:0]  WR_COL, RD_COL;
  logic [2:0]  WR_BA, RD_BA;
  logic        WR_GNT, RD_GNT, DONE, REF, WRITE, READ;
  logic [14:0] ROW_OUT;
  logic [9:0]  COL_OUT;
  logic [2:0]  BA_OUT;
  logic [3:0]  PEND_CNT;
  logic        ERR_TOUT, ERR_OVF;

  always #5 CLK = ~CLK;

  ddr_cmd_scheduler #(.TREFI(TREFI), .MAX_PEND(MAX_PEND), .TOUT(TOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .WR_REQ(WR_REQ), .WR_ROW(WR_ROW), .WR_COL(WR_COL), .WR_BA(WR_BA),
    .RD_REQ(RD_REQ), .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_BA(RD_BA),
    .SM_IDLE(SM_IDLE),
    .WR_GNT(WR_GNT), .RD_GNT(RD_GNT), .DONE(DONE),
    .REF(REF), .WRITE(WRITE), .READ(READ),
    .ROW_OUT(ROW_OUT), .COL_OUT(COL_OUT), .BA_OUT(BA_OUT),
    .PEND_CNT(PEND_CNT), .ERR_TOUT(ERR_TOUT), .ERR_OVF(ERR_OVF)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle-position in the refresh interval, owed
  // refresh count, handshake phase and how long the phase has lasted.
  int  m_tmr, m_pend, m_phase, m_cmd, m_age;
  bit  m_last_wr, m_etout, m_eovf, e_wgnt, e_rgnt, e_done;
  logic [14:0] e_row;
  logic [9:0]  e_col;
  logic [2:0]  e_ba;

  // Environment state.
  int mode, mode_hold, busy;
  bit react_always, fixed_busy, auto_req, hold_both, rand_modes;
  int done_cnt, cyc;
  bit prev_ref;
  int ref_t[$];
  int gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tmr = 0; m_pend = 0; m_phase = P_IDLE; m_cmd = 0; m_age = 0;
    m_last_wr = 0; m_etout = 0; m_eovf = 0;
    e_wgnt = 0; e_rgnt = 0; e_done = 0;
    e_row = '0; e_col = '0; e_ba = '0;
  endtask

  task automatic model_step();
    bit wrapped, ref_fin;
    if (!RESET) begin
      model_reset();
      return;
    end
    wrapped = (m_tmr == TREFI - 1);
    m_tmr   = (m_tmr + 1) % TREFI;
    e_wgnt = 0; e_rgnt = 0; e_done = 0; ref_fin = 0;
    case (m_phase)
      P_IDLE: if (SM_IDLE) begin
        if (m_pend > 0) begin
          m_cmd = C_REF; m_phase = P_ISSUE;
        end else if (WR_REQ && (!RD_REQ || !m_last_wr)) begin
          m_cmd = C_WR; m_phase = P_ISSUE; e_wgnt = 1; m_last_wr = 1;
          e_row = WR_ROW; e_col = WR_COL; e_ba = WR_BA;
        end else if (RD_REQ) begin
          m_cmd = C_RD; m_phase = P_ISSUE; e_rgnt = 1; m_last_wr = 0;
          e_row = RD_ROW; e_col = RD_COL; e_ba = RD_BA;
        end
      end
      P_ISSUE: begin m_phase = P_ACK; m_age = 0; end
      P_ACK: begin
        if (!SM_IDLE) begin m_phase = P_DONE; m_age = 0; end
        else begin
          m_age++;
          if (m_age >= TOUT) begin m_phase = P_IDLE; m_etout = 1; end
        end
      end
      default: begin
        if (SM_IDLE) begin
          e_done = 1; m_phase = P_IDLE; ref_fin = (m_cmd == C_REF);
        end else begin
          m_age++;
          if (m_age >= TOUT) begin m_phase = P_IDLE; m_etout = 1; end
        end
      end
    endcase
    if (wrapped && !ref_fin) begin
      if (m_pend == MAX_PEND) m_eovf = 1;
      else m_pend++;
    end else if (ref_fin && !wrapped) begin
      m_pend--;
    end
  endtask

  task automatic compare();
    bit x_ref, x_wr, x_rd;
    cyc++;
    x_ref = (m_phase == P_ACK) && (m_cmd == C_REF);
    x_wr  = (m_phase == P_ACK) && (m_cmd == C_WR);
    x_rd  = (m_phase == P_ACK) && (m_cmd == C_RD);
    chk("pulses", 32'({WR_GNT, RD_GNT, DONE, REF, WRITE, READ}),
        32'({e_wgnt, e_rgnt, e_done, x_ref, x_wr, x_rd}));
    chk("addr", 32'({ROW_OUT, COL_OUT, BA_OUT}), 32'({e_row, e_col, e_ba}));
    chk("pend", 32'(PEND_CNT), 32'(m_pend));
    chk("errs", 32'({ERR_TOUT, ERR_OVF}), 32'({m_etout, m_eovf}));
    if (WR_GNT === 1'b1) begin
      gnt_log.push_back(1);
      chk("wr_gnt_addr", 32'({ROW_OUT, COL_OUT, BA_OUT}), 32'({WR_ROW, WR_COL, WR_BA}));
    end
    if (RD_GNT === 1'b1) begin
      gnt_log.push_back(2);
      chk("rd_gnt_addr", 32'({ROW_OUT, COL_OUT, BA_OUT}), 32'({RD_ROW, RD_COL, RD_BA}));
    end
    if (DONE === 1'b1) done_cnt++;
    if (REF === 1'b1 && !prev_ref) ref_t.push_back(cyc);
    prev_ref = (REF === 1'b1);
  endtask

  task automatic env_update();
    if (WR_GNT === 1'b1) begin
      WR_REQ = hold_both;
      WR_ROW = 15'($urandom); WR_COL = 10'($urandom); WR_BA = 3'($urandom);
    end else if (auto_req) begin
      if (!WR_REQ && $urandom_range(0, 7) == 0) begin
        WR_REQ = 1'b1;
        WR_ROW = 15'($urandom); WR_COL = 10'($urandom); WR_BA = 3'($urandom);
      end else if (WR_REQ && $urandom_range(0, 63) == 0) begin
        WR_REQ = 1'b0;
      end
    end
    if (RD_GNT === 1'b1) begin
      RD_REQ = hold_both;
      RD_ROW = 15'($urandom); RD_COL = 10'($urandom); RD_BA = 3'($urandom);
    end else if (auto_req) begin
      if (!RD_REQ && $urandom_range(0, 7) == 0) begin
        RD_REQ = 1'b1;
        RD_ROW = 15'($urandom); RD_COL = 10'($urandom); RD_BA = 3'($urandom);
      end else if (RD_REQ && $urandom_range(0, 63) == 0) begin
        RD_REQ = 1'b0;
      end
    end
    if (mode_hold > 0) begin
      mode_hold--;
      if (mode_hold == 0) mode = 0;
    end else if (rand_modes && $urandom_range(0, 299) == 0) begin
      mode = $urandom_range(1, 2);
      mode_hold = $urandom_range(5, 25);
    end
    if (mode == 1) begin
      SM_IDLE = 1'b1; busy = 0;
    end else if (mode == 2) begin
      SM_IDLE = 1'b0; busy = 0;
    end else if (busy > 0) begin
      busy--;
      SM_IDLE = (busy == 0);
    end else if ((REF | WRITE | READ) === 1'b1 &&
                 (react_always || $urandom_range(0, 2) != 0)) begin
      SM_IDLE = 1'b0;
      busy = fixed_busy ? 3 : $urandom_range(1, 4);
    end else begin
      SM_IDLE = 1'b1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    compare();
    env_update();
  endtask

  initial begin
    int n, cnt, d0, r0, maxp, per;
    bit ref_seen;
    RESET = 1'b0; WR_REQ = 1'b0; RD_REQ = 1'b0; SM_IDLE = 1'b1;
    WR_ROW = '0; WR_COL = '0; WR_BA = '0; RD_ROW = '0; RD_COL = '0; RD_BA = '0;
    mode = 0; mode_hold = 0; busy = 0;
    react_always = 1; fixed_busy = 1; auto_req = 0; hold_both = 0; rand_modes = 0;
    done_cnt = 0; cyc = 0; prev_ref = 0;
    model_reset();

    // Reset state
    repeat (3) step();
    chk("reset_ctrl", 32'({WR_GNT, RD_GNT, DONE, REF, WRITE, READ, PEND_CNT, ERR_TOUT, ERR_OVF}), 32'd0);
    chk("reset_addr", 32'({ROW_OUT, COL_OUT, BA_OUT}), 32'd0);
    RESET = 1'b1;

    // Periodic refresh, 3-cycle busy downstream, no requests
    r0 = ref_t.size(); d0 = done_cnt; maxp = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (int'(PEND_CNT) > maxp) maxp = int'(PEND_CNT);
    end
    chk("ref_count", 32'(ref_t.size() - r0), 32'd2);
    chk("ref_done_count", 32'(done_cnt - d0), 32'd2);
    chk("ref_max_pend", 32'(maxp), 32'd1);
    chk("ref_pend_end", 32'(PEND_CNT), 32'd0);
    per = (ref_t.size() >= r0 + 2) ? ref_t[r0 + 1] - ref_t[r0] : -1;
    chk("ref_period", 32'(per), 32'(TREFI));

    // Both requesters held high: grants alternate starting with write
    fixed_busy = 0; hold_both = 1;
    WR_ROW = 15'($urandom); WR_COL = 10'($urandom); WR_BA = 3'($urandom);
    RD_ROW = 15'($urandom); RD_COL = 10'($urandom); RD_BA = 3'($urandom);
    WR_REQ = 1'b1; RD_REQ = 1'b1;
    gnt_log.delete();
    n = 0;
    while (gnt_log.size() < 6 && n < 400) begin step(); n++; end
    for (int i = 0; i < 6; i++) begin
      chk("rr_order", 32'((i < gnt_log.size()) ? gnt_log[i] : 0), 32'((i % 2 == 0) ? 1 : 2));
    end
    hold_both = 0; WR_REQ = 1'b0; RD_REQ = 1'b0;
    repeat (20) step();

    // Timer wrap while a write sits in ACKWAIT
    n = 0;
    while (m_tmr != TREFI - 20 && n < 200) begin step(); n++; end
    mode = 1;
    while (m_tmr != TREFI - 6 && n < 400) begin step(); n++; end
    WR_REQ = 1'b1; WR_ROW = 15'($urandom); WR_COL = 10'($urandom); WR_BA = 3'($urandom);
    n = 0;
    while (WRITE !== 1'b1 && n < 10) begin step(); n++; end
    chk("wrap_wr_strobe", 32'(WRITE), 32'd1);
    repeat (4) step();
    chk("wrap_wr_held", 32'(WRITE), 32'd1);
    chk("wrap_pend_1", 32'(PEND_CNT), 32'd1);
    mode = 0; react_always = 1;
    d0 = done_cnt; ref_seen = 0; n = 0;
    while (done_cnt == d0 && n < 30) begin
      step(); n++;
      if (REF === 1'b1) ref_seen = 1;
    end
    chk("wrap_wr_done", 32'(done_cnt - d0), 32'd1);
    chk("wrap_no_ref_first", 32'(ref_seen), 32'd0);
    n = 0;
    while (REF !== 1'b1 && n < 10) begin step(); n++; end
    chk("wrap_ref_next", 32'(REF), 32'd1);
    chk("wrap_pend_during", 32'(PEND_CNT), 32'd1);
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 30) begin step(); n++; end
    chk("wrap_pend_0", 32'(PEND_CNT), 32'd0);

    // SM_IDLE stuck high after WRITE: timeout
    mode = 1; d0 = done_cnt;
    WR_REQ = 1'b1; WR_ROW = 15'($urandom); WR_COL = 10'($urandom); WR_BA = 3'($urandom);
    n = 0;
    while (WRITE !== 1'b1 && n < 10) begin step(); n++; end
    chk("tout_wr_strobe", 32'(WRITE), 32'd1);
    cnt = 0;
    while (WRITE === 1'b1 && cnt < 50) begin cnt++; step(); end
    chk("tout_len", 32'(cnt), 32'(TOUT));
    repeat (3) step();
    chk("tout_no_done", 32'(done_cnt - d0), 32'd0);
    chk("tout_err", 32'(ERR_TOUT), 32'd1);

    // SM_IDLE stuck low: refresh debt saturates, then overflows
    mode = 2; n = 0;
    while (PEND_CNT !== 4'd8 && n < 10 * TREFI) begin step(); n++; end
    chk("ovf_pend_sat", 32'(PEND_CNT), 32'd8);
    chk("ovf_not_yet", 32'(ERR_OVF), 32'd0);
    cnt = 0;
    while (ERR_OVF !== 1'b1 && cnt < 2 * TREFI) begin step(); cnt++; end
    chk("ovf_9th_wrap", 32'(cnt), 32'(TREFI));
    chk("ovf_pend_held", 32'(PEND_CNT), 32'd8);
    RESET = 1'b0; mode = 0;
    step();
    chk("reset2_ctrl", 32'({WR_GNT, RD_GNT, DONE, REF, WRITE, READ, PEND_CNT, ERR_TOUT, ERR_OVF}), 32'd0);
    RESET = 1'b1;

    // Reset pulse during ACKWAIT of a read
    mode = 1;
    RD_REQ = 1'b1; RD_ROW = 15'($urandom); RD_COL = 10'($urandom); RD_BA = 3'($urandom);
    n = 0;
    while (READ !== 1'b1 && n < 10) begin step(); n++; end
    chk("rst_rd_strobe", 32'(READ), 32'd1);
    repeat (2) step();
    RESET = 1'b0;
    step();
    chk("rst_rd_drop", 32'(READ), 32'd0);
    chk("rst_mid_ctrl", 32'({WR_GNT, RD_GNT, DONE, REF, WRITE, READ, PEND_CNT, ERR_TOUT, ERR_OVF}), 32'd0);
    chk("rst_mid_addr", 32'({ROW_OUT, COL_OUT, BA_OUT}), 32'd0);
    RESET = 1'b1; mode = 0; react_always = 1;
    RD_REQ = 1'b1; RD_ROW = 15'($urandom); RD_COL = 10'($urandom); RD_BA = 3'($urandom);
    n = 0;
    while (RD_GNT !== 1'b1 && n < 10) begin step(); n++; end
    chk("rst_regrant", 32'(RD_GNT), 32'd1);
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 30) begin step(); n++; end
    chk("rst_redone", 32'(done_cnt - d0), 32'd1);

    // Randomized traffic, downstream stalls and occasional resets
    auto_req = 1; rand_modes = 1; react_always = 0;
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 999) != 0);
      step();
    end
    RESET = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
